// File: rtl/unified_mem.sv
// rtl/unified_mem.sv - multi-cycle single-port 64-bit line memory behind the cache controller
// Optional protocol checker on err enabled by defining MEM_PROTO_CHK_EN.
module unified_mem #(
   parameter int ADDR_W  = 14,
   parameter int LATENCY = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] addr,
   input  logic              re,
   input  logic              we,
   input  logic [63:0]       wdata,
   output logic [63:0]       rdata,
   output logic              rdy,
   output logic              busy,
   output logic              err
);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t              r_state;
   state_t              w_next;
   logic [3:0]          r_cnt;
   logic [ADDR_W-1:0]   r_addr;
   logic [63:0]         r_wdata;
   logic                r_op_wr;
   logic [63:0]         r_rdata;
   logic [63:0]         r_mem [2**ADDR_W];
   logic                w_accept;
   logic                w_last;

   assign w_accept = (r_state == S_IDLE) && (re || we);
   assign w_last   = (r_state == S_BUSY) && (r_cnt == 4'd1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_next = S_BUSY;
         S_BUSY:  if (w_last)   w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Simultaneous re & we is a write: op follows we alone.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt   <= 4'd0;
         r_addr  <= '0;
         r_wdata <= 64'd0;
         r_op_wr <= 1'b0;
         r_rdata <= 64'd0;
      end else begin
         if (w_accept) begin
            r_cnt   <= 4'(LATENCY - 1);
            r_addr  <= addr;
            r_wdata <= wdata;
            r_op_wr <= we;
         end else if (r_state == S_BUSY) begin
            r_cnt <= r_cnt - 4'd1;
         end
         if (w_last && !r_op_wr) r_rdata <= r_mem[r_addr];
      end
   end

   // Array is not reset; a write commits only at the end of DONE.
   always_ff @(posedge clk) begin
      if ((r_state == S_DONE) && r_op_wr) r_mem[r_addr] <= r_wdata;
   end

   assign rdata = r_rdata;
   assign rdy   = (r_state == S_DONE);
   assign busy  = (r_state != S_IDLE);

`ifdef MEM_PROTO_CHK_EN
   logic r_err;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err <= 1'b0;
      end else begin
         if (w_accept && re && we) r_err <= 1'b1;
         if ((r_state == S_BUSY) && (!(re || we) || (addr != r_addr) || (we != r_op_wr)))
            r_err <= 1'b1;
      end
   end
   assign err = r_err;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_unified_mem.sv
// tb/tb_unified_mem.sv - self-checking bench for unified_mem (LATENCY=4, ADDR_W=14)
module tb_unified_mem;

   logic        clk;
   logic        rst_n;
   logic [13:0] addr;
   logic        re;
   logic        we;
   logic [63:0] wdata;
   logic [63:0] rdata;
   logic        rdy;
   logic        busy;
   logic        err;

`ifdef MEM_PROTO_CHK_EN
   localparam logic CHK = 1'b1;
`else
   localparam logic CHK = 1'b0;
`endif

   unified_mem #(.ADDR_W(14), .LATENCY(4)) dut (
      .clk(clk), .rst_n(rst_n), .addr(addr), .re(re), .we(we), .wdata(wdata),
      .rdata(rdata), .rdy(rdy), .busy(busy), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   logic prev_rdy = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // rdy must always be a single-cycle pulse
   always @(negedge clk) begin
      if (rdy) begin
         checks++;
         if (prev_rdy) begin
            errors++;
            $display("FAIL rdy_pulse_width: rdy high on two consecutive cycles, required single pulse");
         end
      end
      prev_rdy <= rdy;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   // Drive a request from a negedge, hold until rdy, drop it in the rdy cycle.
   task automatic access(input logic ire, input logic iwe, input logic [13:0] a,
                         input logic [63:0] d, output int lat, output int busy_n,
                         output int rdy_cyc, output logic [63:0] pre_rd);
      lat = 0; busy_n = 0; rdy_cyc = 0; pre_rd = 64'd0;
      re = ire; we = iwe; addr = a; wdata = d;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (k == 0) pre_rd = rdata;
         if (busy) busy_n++;
         if (rdy) begin
            lat = k + 1;
            rdy_cyc = cyc;
            break;
         end
      end
      re = 1'b0; we = 1'b0;
      if (lat == 0) begin
         errors++; checks++;
         $display("FAIL access_timeout: no rdy within 20 cycles for addr %h", a);
      end
   endtask

   task automatic do_reset();
      re = 1'b0; we = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic        re;
      logic        we;
      logic [13:0] addr;
      logic [63:0] wdata;
      logic [63:0] exp_rdata;
   } vec_t;

   vec_t        vt[10];
   logic [63:0] ref_mem [logic [13:0]];
   logic [63:0] ref_rd;
   logic        ref_rd_valid;
   logic [13:0] pool[8];

   initial begin
      int lat, bn, c1, c2, k, gap, op;
      logic [63:0] pre, d;
      logic [13:0] a;

      vt[0] = '{1'b0, 1'b1, 14'h0B0B, 64'hBBBB_0000_BBBB_0000, 64'h0};
      vt[1] = '{1'b0, 1'b1, 14'h0A0A, 64'hAAAA_5555_AAAA_5555, 64'h0};
      vt[2] = '{1'b1, 1'b0, 14'h0A0A, 64'h0, 64'hAAAA_5555_AAAA_5555};
      vt[3] = '{1'b0, 1'b1, 14'h3C00, 64'h1111_2222_3333_4444, 64'h0};
      vt[4] = '{1'b1, 1'b0, 14'h3C00, 64'h0, 64'h1111_2222_3333_4444};
      vt[5] = '{1'b1, 1'b0, 14'h0B0B, 64'h0, 64'hBBBB_0000_BBBB_0000};
      vt[6] = '{1'b0, 1'b1, 14'h3FFF, 64'hFEDC_BA98_7654_3210, 64'h0};
      vt[7] = '{1'b0, 1'b1, 14'h0000, 64'h0123_4567_89AB_CDEF, 64'h0};
      vt[8] = '{1'b1, 1'b0, 14'h3FFF, 64'h0, 64'hFEDC_BA98_7654_3210};
      vt[9] = '{1'b1, 1'b0, 14'h0000, 64'h0, 64'h0123_4567_89AB_CDEF};

      rst_n = 1'b0; re = 1'b0; we = 1'b0; addr = 14'h0; wdata = 64'h0;
      #13;
      chk("reset_rdy",   64'(rdy),   64'd0);
      chk("reset_busy",  64'(busy),  64'd0);
      chk("reset_rdata", rdata,      64'd0);
      chk("reset_err",   64'(err),   64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Hold re through DONE: one pulse, 4-cycle latency, busy for 4 cycles
      @(negedge clk);
      re = 1'b1; addr = 14'h0010;
      lat = 0; bn = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (busy) bn++;
         if (rdy) begin lat = i + 1; break; end
      end
      chk("t1_latency", 64'(lat), 64'd4);
      chk("t1_busy_cycles", 64'(bn), 64'd4);
      @(negedge clk);
      chk("t1_no_second_rdy", 64'(rdy), 64'd0);
      chk("t1_idle_after_done", 64'(busy), 64'd0);
      re = 1'b0;

      ref_rd_valid = 1'b0;
      ref_rd = 64'd0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         access(vt[i].re, vt[i].we, vt[i].addr, vt[i].wdata, lat, bn, c1, pre);
         chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd4);
         if (vt[i].we) begin
            if (ref_rd_valid) chk($sformatf("vec%0d_rdata_held", i), rdata, ref_rd);
         end else begin
            chk($sformatf("vec%0d_rdata", i), rdata, vt[i].exp_rdata);
            ref_rd = vt[i].exp_rdata;
            ref_rd_valid = 1'b1;
         end
      end

      // Write-back then fill: second rdy 5 cycles after the first
      @(negedge clk);
      access(1'b0, 1'b1, 14'h0A0A, 64'h0A0A_0A0A_0A0A_0A0A, lat, bn, c1, pre);
      chk("t3_write_rdata_held", rdata, 64'h0123_4567_89AB_CDEF);
      access(1'b1, 1'b0, 14'h0B0B, 64'h0, lat, bn, c2, pre);
      chk("t3_rdy_spacing", 64'(c2 - c1), 64'd5);
      chk("t3_rdata_old_before", pre, 64'h0123_4567_89AB_CDEF);
      chk("t3_fill_rdata", rdata, 64'hBBBB_0000_BBBB_0000);

      // re & we together is a write
      @(negedge clk);
      access(1'b1, 1'b1, 14'h0002, 64'h5, lat, bn, c1, pre);
      chk("t5_latency", 64'(lat), 64'd4);
      chk("t5_rdata_unchanged", rdata, 64'hBBBB_0000_BBBB_0000);
      chk("t5_err", 64'(err), 64'(CHK));
      @(negedge clk);
      access(1'b1, 1'b0, 14'h0002, 64'h0, lat, bn, c1, pre);
      chk("t5_readback", rdata, 64'h5);

      do_reset();
      chk("t6_err_cleared", 64'(err), 64'd0);
      @(negedge clk);
      access(1'b0, 1'b1, 14'h0020, 64'h2020_2020_0000_0020, lat, bn, c1, pre);
      @(negedge clk);
      access(1'b0, 1'b1, 14'h0021, 64'h2121_2121_0000_0021, lat, bn, c1, pre);
      @(negedge clk);
      re = 1'b1; addr = 14'h0020;
      lat = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (i == 0) addr = 14'h0021;
         if (rdy) begin lat = i + 1; break; end
      end
      re = 1'b0;
      chk("t6_latency", 64'(lat), 64'd4);
      chk("t6_latched_addr", rdata, 64'h2020_2020_0000_0020);
      chk("t6_err", 64'(err), 64'(CHK));
      repeat (3) @(negedge clk);
      chk("t6_err_sticky", 64'(err), 64'(CHK));

      // Reset during BUSY of a write: no rdy, no commit
      @(negedge clk);
      access(1'b0, 1'b1, 14'h0001, 64'h0000_0000_C0DE_0001, lat, bn, c1, pre);
      @(negedge clk);
      we = 1'b1; addr = 14'h0001; wdata = 64'hDEAD;
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("t4_busy_in_reset", 64'(busy), 64'd0);
      chk("t4_rdy_in_reset", 64'(rdy), 64'd0);
      we = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      k = 0;
      repeat (6) begin
         @(negedge clk);
         if (rdy) k++;
      end
      chk("t4_no_rdy", 64'(k), 64'd0);
      chk("t4_rdata_reset", rdata, 64'd0);
      access(1'b1, 1'b0, 14'h0001, 64'h0, lat, bn, c1, pre);
      chk("t4_prior_contents", rdata, 64'h0000_0000_C0DE_0001);

      // Randomized traffic against an associative-array reference memory
      for (int i = 0; i < 8; i++) begin
         pool[i] = 14'($urandom_range(0, 16383));
         d = {$urandom, $urandom};
         @(negedge clk);
         access(1'b0, 1'b1, pool[i], d, lat, bn, c1, pre);
         ref_mem[pool[i]] = d;
      end
      ref_rd = 64'h0000_0000_C0DE_0001;
      for (int i = 0; i < 40; i++) begin
         gap = $urandom_range(0, 2);
         op  = $urandom_range(0, 3);
         a   = pool[$urandom_range(0, 7)];
         d   = {$urandom, $urandom};
         repeat (gap) @(negedge clk);
         access(op < 2 ? 1'b1 : (op == 3), op >= 2, a, d, lat, bn, c1, pre);
         if (op >= 2) ref_mem[a] = d;
         else         ref_rd = ref_mem[a];
         chk($sformatf("rnd%0d_latency", i), 64'(lat), gap == 0 ? 64'd5 : 64'd4);
         chk($sformatf("rnd%0d_rdata", i), rdata, ref_rd);
      end

      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
